ram32_fifo_ctrl: RTL and testbench

RAM32_FIFO_CTRL -- requirements
Module: ram32_fifo_ctrl

---
 rtl/ram32_fifo_pkg.sv | 6 +
 rtl/ram32_fifo_ctrl.sv | 76 +++++++
 tb/tb_ram32_fifo_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ram32_fifo_pkg.sv
// ram32_fifo_pkg: shared constants and arbitration state encoding for ram32_fifo_ctrl
package ram32_fifo_pkg;
  localparam int DEPTH = 32;
  localparam int PTR_W = 5;
  typedef enum logic {PRIO_WR = 1'b0, PRIO_RD = 1'b1} prio_e;
endpackage

// File: rtl/ram32_fifo_ctrl.sv
// ram32_fifo_ctrl: FIFO controller for an external 32xWIDTH single-port select RAM plus a fall-through output register.
// Ports: CLK/RST_N (sync, active-low); S_VALID/S_READY/S_DATA push side; M_VALID/M_READY/M_DATA pop side;
// LEVEL total entries (RAM + output register); RAM_WE/RAM_A/RAM_D/RAM_O drive the external RAM bank.
module ram32_fifo_ctrl
  import ram32_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [5:0]       LEVEL,
  output logic             RAM_WE,
  output logic [PTR_W-1:0] RAM_A,
  output logic [WIDTH-1:0] RAM_D,
  input  logic [WIDTH-1:0] RAM_O
);
  localparam logic [5:0] FULL = 6'(DEPTH);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [5:0]       cnt_q, cnt_d, level_q, level_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  prio_e            state_q, state_d;
  logic             out_free, refill_req, bypass, push, pop, wr_grant, rd_grant, contend;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= PRIO_WR;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      m_valid_q <= m_valid_d;
    end
  end
  always_ff @(posedge CLK) m_data_q <= m_data_d;
  // A full RAM cannot compete for the write slot while priority sits with writes,
  // so only a push that could actually be written counts as contention there.
  always_comb begin
    contend = refill_req && S_VALID && (state_q == PRIO_RD || cnt_q < FULL);
    state_d = contend ? (state_q == PRIO_WR ? PRIO_RD : PRIO_WR) : state_q;
  end
  always_comb begin
    out_free   = !m_valid_q || M_READY;
    refill_req = cnt_q != '0 && out_free;
    bypass     = cnt_q == '0 && out_free;
    S_READY    = RST_N && (bypass || (cnt_q < FULL && !(refill_req && state_q == PRIO_RD)));
    push       = S_VALID && S_READY;
    pop        = m_valid_q && M_READY;
    wr_grant   = push && !bypass;
    rd_grant   = refill_req && !wr_grant;
    RAM_WE     = wr_grant;
    RAM_A      = wr_grant ? wr_ptr_q : rd_ptr_q;
    RAM_D      = S_DATA;
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_grant);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd_grant);
    cnt_d      = cnt_q + 6'(wr_grant) - 6'(rd_grant);
    level_d    = level_q + 6'(push) - 6'(pop);
    m_valid_d  = rd_grant || (bypass && push) || (m_valid_q && !pop);
    m_data_d   = rd_grant ? RAM_O : (bypass && push) ? S_DATA : m_data_q;
  end
  assign M_VALID = m_valid_q;
  assign M_DATA  = m_data_q;
  assign LEVEL   = level_q;
endmodule

// File: tb/tb_ram32_fifo_ctrl.sv
// tb_ram32_fifo_ctrl: randomized self-checking bench for ram32_fifo_ctrl against a queue-based reference model
module tb_ram32_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, m_valid, ram_we;
  logic [7:0] m_data, ram_d, ram_o;
  logic [5:0] level;
  logic [4:0] ram_a;
  logic [7:0] mem [32];
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  logic [7:0] popped[$];
  int mv = 0, prio = 0, n_wr = 0, n_rd = 0;
  int obs_rdy, obs_mv, obs_lvl, obs_we, we_seen, last_push;
  logic [7:0] obs_md;
  always #5 clk = ~clk;
  ram32_fifo_ctrl #(.WIDTH(8)) dut (
    .CLK(clk), .RST_N(rst_n), .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data), .LEVEL(level),
    .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_D(ram_d), .RAM_O(ram_o)
  );
  assign ram_o = mem[ram_a];
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic mr);
    int ramc, out_free, rr, byp, rdy, push, pop, wr, rd, contend;
    @(negedge clk);
    rst_n = r; s_valid = v; s_data = d; m_ready = mr;
    #1;
    ramc = q.size() - mv;
    out_free = !mv || mr;
    rr = ramc != 0 && out_free;
    byp = ramc == 0 && out_free;
    rdy = r && (byp || (ramc < 32 && !(rr && prio == 1)));
    push = v && rdy;
    pop = mv && mr;
    wr = push && !byp;
    rd = r && rr && !wr;
    obs_rdy = s_ready; obs_mv = m_valid; obs_lvl = level; obs_md = m_data; obs_we = ram_we;
    if (ram_we === 1'b1) we_seen = 1;
    chk("s_ready", s_ready, rdy);
    chk("ram_we", ram_we, wr);
    chk("level", level, q.size());
    chk("m_valid", m_valid, mv);
    if (mv) chk("m_data", m_data, q[0]);
    if (wr) begin
      chk("wr_addr", ram_a, n_wr % 32);
      chk("ram_d", ram_d, d);
    end else if (r) chk("rd_addr", ram_a, n_rd % 32);
    last_push = push;
    if (!r) begin
      q.delete(); mv = 0; prio = 0; n_wr = 0; n_rd = 0;
    end else begin
      contend = rr && v && (prio == 1 || ramc < 32);
      if (pop) begin
        popped.push_back(q[0]);
        void'(q.pop_front());
      end
      if (push) q.push_back(d);
      n_wr += wr; n_rd += rd;
      if (contend) prio = 1 - prio;
      mv = (rd || (byp && push) || (mv && !pop)) ? 1 : 0;
    end
  endtask
  task automatic do_reset();
    step(0, 0, 0, 0);
    step(0, 1, 8'hFF, 1);
  endtask
  initial begin
    int nxt, cyc;
    do_reset();
    // single push of A5 falls straight into the output register
    we_seen = 0;
    step(1, 0, 0, 0);
    chk("rst_level", obs_lvl, 0);
    chk("rst_valid", obs_mv, 0);
    step(1, 1, 8'hA5, 0);
    step(1, 0, 0, 0);
    chk("a5_valid", obs_mv, 1);
    chk("a5_data", obs_md, 8'hA5);
    chk("a5_level", obs_lvl, 1);
    chk("a5_no_we", we_seen, 0);
    // fill to 33 entries with M_READY low, then attempt a 34th push
    do_reset();
    for (int i = 0; i < 34; i++) step(1, 1, 8'(i + 8'h10), 0);
    chk("full_sready", obs_rdy, 0);
    chk("full_level", obs_lvl, 33);
    // full FIFO with push and pop held: refill/write alternate
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 8'(8'h80 + i), 1);
      chk("alt_sready", obs_rdy, i % 2);
      chk("alt_level", (obs_lvl >= 32 && obs_lvl <= 33) ? 1 : 0, 1);
    end
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1);
    chk("drained_level", obs_lvl, 0);
    // ordered sequence 0..99 against random pops
    do_reset();
    popped.delete();
    nxt = 0; cyc = 0;
    while (popped.size() < 100 && cyc < 3000) begin
      step(1, (nxt < 100) && ($urandom_range(0, 1) == 1), 8'(nxt), $urandom_range(0, 1) == 1);
      if (last_push) nxt++;
      cyc++;
    end
    chk("seq_count", popped.size(), 100);
    for (int i = 0; i < popped.size() && i < 100; i++) chk("seq_order", popped[i], i);
    // reset mid-transfer at LEVEL=10, then a bypass push
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 8'(i), 0);
    step(1, 0, 0, 0);
    chk("pre_rst_level", obs_lvl, 10);
    step(0, 1, 8'h55, 1);
    chk("rst_sready", obs_rdy, 0);
    chk("rst_we", obs_we, 0);
    step(1, 0, 0, 0);
    chk("mid_rst_level", obs_lvl, 0);
    chk("mid_rst_valid", obs_mv, 0);
    step(1, 1, 8'h3C, 0);
    chk("3c_we", obs_we, 0);
    step(1, 0, 0, 0);
    chk("3c_valid", obs_mv, 1);
    chk("3c_data", obs_md, 8'h3C);
    // free-running random traffic
    for (int i = 0; i < 600; i++) step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
